// File: rtl/btn_debounce_tick.sv
// Push-button front end: turns divider tap rising edges into sample ticks, then
// debounces each button and adds press auto-repeat, all in the clk domain.
module btn_debounce_tick #(
    parameter int N            = 4,
    parameter int STABLE_TICKS = 4,
    parameter int HOLD_TICKS   = 32,
    parameter int REPEAT_TICKS = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         div_tap,
    input  logic [N-1:0] btn_raw,
    output logic [N-1:0] btn_level,
    output logic [N-1:0] btn_press,
    output logic [N-1:0] btn_release,
    output logic         tick
);

    // state  | meaning
    // IDLE   | button released, waiting for an accepted press
    // HOLD   | pressed, counting ticks until auto-repeat starts
    // REPEAT | held long enough, pulsing press every REPEAT_TICKS
    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

    localparam logic [3:0] STABLE_W = 4'(STABLE_TICKS);
    localparam logic [7:0] HOLD_W   = 8'(HOLD_TICKS);
    localparam logic [7:0] REP_W    = 8'(REPEAT_TICKS);

    logic tap_s1_q, tap_s2_q, tap_e_q;
    logic tick_q, tick_d;

    always_comb begin
        tick_d = tap_s2_q & ~tap_e_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tap_s1_q <= 1'b0;
            tap_s2_q <= 1'b0;
            tap_e_q  <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            tap_s1_q <= div_tap;
            tap_s2_q <= tap_s1_q;
            tap_e_q  <= tap_s2_q;
            tick_q   <= tick_d;
        end
    end

    assign tick = tick_q;

    for (genvar i = 0; i < N; i++) begin : g_btn
        logic       b_s1_q, b_s2_q;
        logic [3:0] cnt_q, cnt_d;
        logic [7:0] hold_q, hold_d;
        logic [7:0] rep_q, rep_d;
        logic       level_q, level_d;
        logic       press_q, press_d;
        logic       rel_q, rel_d;
        logic       accept;
        state_t     st_q, st_d;

        always_comb begin
            cnt_d   = cnt_q;
            hold_d  = hold_q;
            rep_d   = rep_q;
            level_d = level_q;
            press_d = 1'b0;
            rel_d   = 1'b0;
            accept  = 1'b0;
            st_d    = st_q;
            if (tick_q) begin
                if (b_s2_q == level_q) begin
                    cnt_d = '0;
                end else if (cnt_q + 4'd1 == STABLE_W) begin
                    accept  = 1'b1;
                    cnt_d   = '0;
                    level_d = ~level_q;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end

                // A release accepted on the same tick beats any repeat due.
                unique case (st_q)
                    IDLE: begin
                        if (accept && !level_q) begin
                            press_d = 1'b1;
                            hold_d  = '0;
                            st_d    = HOLD;
                        end
                    end
                    HOLD: begin
                        if (accept) begin
                            rel_d  = 1'b1;
                            hold_d = '0;
                            rep_d  = '0;
                            st_d   = IDLE;
                        end else if (hold_q + 8'd1 == HOLD_W) begin
                            press_d = 1'b1;
                            hold_d  = '0;
                            rep_d   = '0;
                            st_d    = REPEAT;
                        end else begin
                            hold_d = hold_q + 8'd1;
                        end
                    end
                    REPEAT: begin
                        if (accept) begin
                            rel_d  = 1'b1;
                            hold_d = '0;
                            rep_d  = '0;
                            st_d   = IDLE;
                        end else if (rep_q + 8'd1 == REP_W) begin
                            press_d = 1'b1;
                            rep_d   = '0;
                        end else begin
                            rep_d = rep_q + 8'd1;
                        end
                    end
                    default: st_d = IDLE;
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                b_s1_q  <= 1'b0;
                b_s2_q  <= 1'b0;
                cnt_q   <= '0;
                hold_q  <= '0;
                rep_q   <= '0;
                level_q <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                st_q    <= IDLE;
            end else begin
                b_s1_q  <= btn_raw[i];
                b_s2_q  <= b_s1_q;
                cnt_q   <= cnt_d;
                hold_q  <= hold_d;
                rep_q   <= rep_d;
                level_q <= level_d;
                press_q <= press_d;
                rel_q   <= rel_d;
                st_q    <= st_d;
            end
        end

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = rel_q;
    end

endmodule

// File: tb/tb_btn_debounce_tick.sv
// Scoreboard bench for btn_debounce_tick: stimulus queues expected tick cycles and
// press/release events tagged by sample-tick number; a monitor pops and compares.
module tb_btn_debounce_tick;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       div_tap = 1'b0;
    logic [3:0] btn_raw = 4'b0000;
    logic [3:0] btn_level, btn_press, btn_release;
    logic       tick;

    btn_debounce_tick #(
        .N(4), .STABLE_TICKS(4), .HOLD_TICKS(32), .REPEAT_TICKS(8)
    ) dut (
        .clk(clk), .rst(rst), .div_tap(div_tap), .btn_raw(btn_raw),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
        .tick(tick)
    );

    typedef struct {
        int         tk;
        logic [3:0] pr;
        logic [3:0] rl;
        logic [3:0] lv;
    } ev_t;

    ev_t        evq[$];
    int         tq[$];
    int         cyc = 0;
    int         ntick = 0;
    int         errors = 0;
    int         checks = 0;
    logic [3:0] phase = 4'd0;
    logic [3:0] lv_exp = 4'b0000;
    int         t;

    initial forever #5 clk = ~clk;

    // div_tap: period-16 square wave; each rising edge predicts a tick 3 clk later
    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        phase   = phase + 4'd1;
        div_tap = phase[3];
        if (phase == 4'd8 && rst) tq.push_back(cyc + 3);
    end

    initial forever begin
        logic exp_t;
        ev_t  e;
        @(negedge clk);
        if (!rst) begin
            checks++;
            if ({btn_level, btn_press, btn_release, tick} !== 13'd0) begin
                errors++;
                $display("FAIL reset_outputs: level=%b press=%b release=%b tick=%b, required all 0",
                         btn_level, btn_press, btn_release, tick);
            end
        end else begin
            exp_t = 1'b0;
            if (tq.size() > 0 && tq[0] == cyc) begin
                exp_t = 1'b1;
                void'(tq.pop_front());
            end
            if (exp_t || tick !== 1'b0) begin
                checks++;
                if (tick !== exp_t) begin
                    errors++;
                    $display("FAIL tick_timing: cycle %0d tick=%b, required %b", cyc, tick, exp_t);
                end
            end
            if (exp_t) ntick++;
            if ((|btn_press) !== 1'b0 || (|btn_release) !== 1'b0) begin
                checks++;
                if (evq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: tick %0d press=%b release=%b level=%b, required no pulse",
                             ntick, btn_press, btn_release, btn_level);
                end else begin
                    e = evq.pop_front();
                    if (e.tk != ntick || btn_press !== e.pr || btn_release !== e.rl || btn_level !== e.lv) begin
                        errors++;
                        $display("FAIL event: got tick %0d press=%b release=%b level=%b, required tick %0d press=%b release=%b level=%b",
                                 ntick, btn_press, btn_release, btn_level, e.tk, e.pr, e.rl, e.lv);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic void expect_ev(input int tk, input logic [3:0] pr, input logic [3:0] rl);
        ev_t e;
        lv_exp = (lv_exp | pr) & ~rl;
        e.tk = tk;
        e.pr = pr;
        e.rl = rl;
        e.lv = lv_exp;
        evq.push_back(e);
    endfunction

    task automatic wait_tick(input int tgt);
        int budget;
        budget = (tgt - ntick + 2) * 20 + 50;
        do begin
            @(posedge clk);
            #3;
            budget--;
        end while (ntick < tgt && budget > 0);
        if (ntick < tgt) begin
            checks++;
            errors++;
            $display("FAIL wait_tick: reached tick %0d, required %0d", ntick, tgt);
        end
    endtask

    // release reset while div_tap is low so no spurious edge is seen
    task automatic release_rst();
        do begin
            @(posedge clk);
            #3;
        end while (phase != 4'd2);
        rst = 1'b1;
    endtask

    initial begin
        btn_raw = 4'b1111;
        rst     = 1'b0;
        repeat (40) @(posedge clk);
        release_rst();
        t = ntick;
        expect_ev(t + 4, 4'b1111, 4'b0000);
        wait_tick(t + 4);
        btn_raw = 4'b0000;
        expect_ev(t + 8, 4'b0000, 4'b1111);
        wait_tick(t + 9);

        // bounce rejection on button 0
        t = ntick;
        for (int i = 0; i < 10; i++) begin
            btn_raw[0] = (i % 2 == 0);
            wait_tick(t + i + 1);
        end
        btn_raw[0] = 1'b1;
        expect_ev(t + 14, 4'b0001, 4'b0000);
        wait_tick(t + 14);
        btn_raw[0] = 1'b0;
        expect_ev(t + 18, 4'b0000, 4'b0001);
        wait_tick(t + 19);

        // auto-repeat on button 1
        t = ntick;
        btn_raw[1] = 1'b1;
        expect_ev(t + 4,  4'b0010, 4'b0000);
        expect_ev(t + 36, 4'b0010, 4'b0000);
        expect_ev(t + 44, 4'b0010, 4'b0000);
        expect_ev(t + 52, 4'b0010, 4'b0000);
        expect_ev(t + 60, 4'b0010, 4'b0000);
        wait_tick(t + 60);
        btn_raw[1] = 1'b0;
        expect_ev(t + 64, 4'b0000, 4'b0010);
        wait_tick(t + 80);

        // simultaneous press on 2 and release on 3
        t = ntick;
        btn_raw[3] = 1'b1;
        expect_ev(t + 4, 4'b1000, 4'b0000);
        wait_tick(t + 6);
        btn_raw[2] = 1'b1;
        btn_raw[3] = 1'b0;
        expect_ev(t + 10, 4'b0100, 4'b1000);
        wait_tick(t + 10);
        btn_raw[2] = 1'b0;
        expect_ev(t + 14, 4'b0000, 4'b0100);
        wait_tick(t + 15);

        // reset while button 1 is repeating
        t = ntick;
        btn_raw[1] = 1'b1;
        expect_ev(t + 4,  4'b0010, 4'b0000);
        expect_ev(t + 36, 4'b0010, 4'b0000);
        expect_ev(t + 44, 4'b0010, 4'b0000);
        wait_tick(t + 46);
        rst = 1'b0;
        tq.delete();
        lv_exp = 4'b0000;
        repeat (20) @(posedge clk);
        release_rst();
        t = ntick;
        expect_ev(t + 4,  4'b0010, 4'b0000);
        expect_ev(t + 36, 4'b0010, 4'b0000);
        wait_tick(t + 37);
        btn_raw[1] = 1'b0;
        expect_ev(t + 41, 4'b0000, 4'b0010);
        wait_tick(t + 45);

        checks++;
        if (evq.size() != 0) begin
            errors++;
            $display("FAIL pending_events: %0d expected events never seen, required 0", evq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/btn_debounce_tick.md
Name: btn_debounce_tick

Overview:
- Consumer of the free-running divider output. Takes one divider tap bit and converts its rising edges into single-cycle sample enables in the system clock domain. Those enables drive per-button debounce and auto-repeat logic.
- Sits between the board push-buttons and the score counters, so every score event is exactly one clk-wide pulse.

Parameters:
N, 4, number of buttons debounced in parallel
STABLE_TICKS, 4, consecutive agreeing sample ticks needed to accept a new level (1..15)
HOLD_TICKS, 32, sample ticks a press must be held before auto-repeat starts (1..255)
REPEAT_TICKS, 8, sample ticks between auto-repeat pulses once repeating (1..255)

Ports:
clk  input  1  system clock; the same clock that drives the divider
rst  input  1  asynchronous, active-low reset; asserted when 0, released synchronously to clk by the top level
div_tap  input  1  one bit of the free-running divider count, treated as asynchronous
btn_raw  input  N  raw, bouncing button levels; 1 = pressed; asynchronous
btn_level  output  N  debounced button level
btn_press  output  N  1-cycle pulse on accepted 0->1 transition, and on each auto-repeat
btn_release  output  N  1-cycle pulse on accepted 1->0 transition
tick  output  1  1-cycle sample enable, for observation and reuse

Behaviour:
- Reset (rst=0, async):
  - All synchronizer flops, counters, btn_level, btn_press, btn_release and tick go to 0.
  - Per-button FSM goes to IDLE.
  - Reset mid-bounce or mid-repeat discards all progress; no pulse is emitted on release of reset.
- Tap synchronization:
  - div_tap passes through a 2-flop synchronizer, then a third edge flop.
  - tick = 1 for exactly one clk when sync=1 and edge flop=0 (registered output).
  - Latency: 3 clk from div_tap rising to tick high.
  - Falling edges of div_tap generate nothing.
  - If div_tap is held constant, no ticks occur and all state freezes.
- Button synchronization: each btn_raw bit goes through its own 2-flop synchronizer every clk, independent of tick.
- Debounce, per button, evaluated only on cycles where tick=1:
  - cnt is 4 bits.
  - If synced bit == btn_level: cnt <= 0.
  - Otherwise cnt <= cnt+1. When cnt+1 == STABLE_TICKS, btn_level toggles and cnt <= 0.
  - A single disagreeing sample followed by an agreeing one restarts the count (bounce rejection).
- Pulses:
  - btn_press/btn_release are registered and high for exactly the clk after btn_level changes.
  - Never high two consecutive cycles.
  - Never both high for the same button.
- Auto-repeat FSM, per button, advancing only on tick:
  - IDLE:
    - On accepted press: emit press pulse, hold_cnt <= 0, go to HOLD.
  - HOLD:
    - hold_cnt counts ticks while btn_level=1 (8 bits).
    - When hold_cnt+1 == HOLD_TICKS: emit press pulse, rep_cnt <= 0, go to REPEAT.
  - REPEAT:
    - rep_cnt counts ticks (8 bits).
    - When rep_cnt+1 == REPEAT_TICKS: emit press pulse, rep_cnt <= 0.
  - From HOLD or REPEAT, accepted release: emit release pulse, go to IDLE, clear counters. Release takes priority over a repeat due on the same tick.
- Counters never wrap; they are cleared on reaching terminal.
- Buttons are fully independent: simultaneous events on several buttons pulse in the same cycle.

Test Plan:
- Reset:
  - Stimulus: rst=0 with btn_raw=4'b1111 and div_tap toggling; then release rst.
  - Required response: all outputs stay 0 throughout reset. First btn_press[*] occurs only after 4 further ticks (default STABLE_TICKS).
- Tick generation:
  - Stimulus: div_tap square wave of period 16 clk.
  - Required response: tick pulses exactly once per 16 clk, 3 clk after each rising edge. No tick on falling edges.
- Bounce rejection:
  - Stimulus: btn_raw[0] toggles on alternate ticks for 10 ticks, then held 1.
  - Required response: no pulse during the toggling. Exactly one btn_press[0] on the 4th stable tick. btn_level[0]=1 from the following clk.
- Auto-repeat:
  - Stimulus: btn_raw[1] held high for 60 ticks, HOLD_TICKS=32, REPEAT_TICKS=8.
  - Required response: 1 initial press + 1 at hold expiry + 3 repeats = 5 btn_press[1] pulses.
  - Then release: exactly one btn_release[1] after 4 ticks, and no further press pulses.
- Simultaneous events:
  - Stimulus: btn_raw[2] rises and btn_raw[3] falls (btn_level[3] previously 1) at the same clk.
  - Required response: btn_press[2] and btn_release[3] are asserted in the same cycle.
- Reset mid-repeat:
  - Stimulus: pull rst=0 while button 1 is in REPEAT.
  - Required response: outputs clear immediately. With button still held after rst=1, the full sequence restarts: press pulse after STABLE_TICKS, repeat only after HOLD_TICKS.
